ones_run_gen: RTL and testbench
===============================

Name: ones_run_gen

Overview:
- Serial stimulus transmitter that drives the consecutive-ones detector.
- Each accepted request produces one run of `len` consecutive 1s on `o`, followed by a fixed zero gap.
- Counts runs sent, and runs long enough (>= THRESH) to trigger a detector, so a checker can compare the count against detector hits.
- Sits upstream of the detector on the same single-bit serial line.

Parameters:
- LEN_W, 4, width of run-length request; maximum run = 2^LEN_W - 1.
- GAP_CYC, 1, number of 0 cycles after each run; legal range 1..15.
- THRESH, 3, minimum run length counted in `hits`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low. While 0, all state clears immediately.
- start  input  1  request strobe; accepted when start=1 and ready=1 at a clk edge.
- len  input  LEN_W  run length, sampled with an accepted start.
- ready  output  1  high only in IDLE.
- o  output  1  serial bit, registered.
- last  output  1  high during the final 1 of a run.
- done  output  1  one-cycle pulse on the final gap cycle.
- runs  output  8  runs completed, wraps 255->0.
- hits  output  8  completed runs with len >= THRESH, wraps 255->0.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, o=0, ready=1, last=0, done=0, runs=0, hits=0, internal counters=0.
- State IDLE:
  - o=0, ready=1.
  - On accepted start: latch len into len_q and load the cycle counter.
  - len_q>0 -> go to ONES.
  - len_q==0 -> go directly to GAP; no 1s are emitted.
- State ONES:
  - o=1 for exactly len_q cycles; ready=0.
  - Latency: start accepted at edge k -> o=1 from edge k to edge k+len_q, i.e. o rises the cycle after acceptance.
  - last=1 during the len_q-th 1.
  - Then go to GAP.
- State GAP:
  - o=0 for exactly GAP_CYC cycles; done=1 only in the final gap cycle.
  - On the exit edge: runs increments; hits increments if len_q >= THRESH.
  - A len=0 run also increments runs.
  - Then go to IDLE.
- start is ignored when ready=0; it is neither queued nor latched.
- len changing while busy has no effect; only len_q is used.
- Back-to-back requests: start held high in IDLE is accepted on the first ready cycle.
  - The line therefore carries run, GAP_CYC zeros, one IDLE zero, next run.
  - Minimum separation between runs = GAP_CYC+1 zeros.
- Counter arithmetic: 8-bit, unsigned, wrap-around, no saturation. runs and hits can increment on the same edge.
- rst asserted mid-run: o drops to 0 immediately (asynchronous). No done pulse; counters clear.
- Only one of o or done is ever high in a given cycle.

Optional Feature:
- Macro: ONES_RUN_REPEAT_EN.
- Defined:
  - Adds input port `rpt` (1 bit).
  - If rpt=1 on the final GAP cycle, go directly to ONES, reloading the count from len_q. ready stays 0.
  - done still pulses, and runs/hits still increment, for each run.
  - If len_q==0 with rpt=1, the FSM stays in GAP, repeating zero-gaps, with done pulsing every GAP_CYC cycles.
- Undefined: the rpt port is absent, and the FSM always returns to IDLE after GAP.

Decomposition:
- Package ones_run_pkg contains:
  - enum state_t {IDLE, ONES, GAP}, 2 bits.
  - localparam CNT_W = 8.
  - Default GAP_CYC and THRESH constants.
- Sub-module: wrap_cnt (parameterised width, enable, async active-low clear). Instantiated twice, for runs and hits.
- The FSM and the down-counter stay in the top module.

Test Plan:
- Reset: rst=0 at t=1, release at t=6 -> o=0, ready=1, runs=0, hits=0. A mid-run rst=0 forces o=0 within the same cycle, with no clock edge needed.
- start with len=3, GAP_CYC=1:
  - o = 1,1,1,0 on the four cycles after acceptance.
  - last high on the third 1; done on the 0.
  - Afterwards runs=1, hits=1, ready=1.
- len=2 then len=5, start held high:
  - Stream 1,1,0,0,1,1,1,1,1,0.
  - runs=2, hits=1.
  - start while busy is ignored, so exactly two runs are produced.
- len=0 -> o stays 0; done pulses once, 1 cycle after acceptance; runs+1, hits unchanged. len=15 -> 15 consecutive 1s, hits+1.
- Wrap-around: 256 runs of len=3 -> runs=0 and hits=0 after the 256th; 255 runs -> both equal 255.
- With ONES_RUN_REPEAT_EN, len=3, rpt=1 held:
  - Continuous 1,1,1,0 pattern with ready=0 throughout.
  - Drop rpt -> returns to IDLE after the current gap.
  - runs equals the number of done pulses.

Source files
------------

// File: rtl/ones_run_pkg.sv
// Shared types and defaults for the ones-run stimulus generator.
// Optional repeat mode is selected by ONES_RUN_REPEAT_EN in the top module.
package ones_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONES = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CNT_W       = 8;
  localparam int GAP_CYC_DEF = 1;
  localparam int THRESH_DEF  = 3;

endpackage

// File: rtl/ones_run_gen_wrap_cnt.sv
// Wrap-around event counter: +1 per enabled cycle, result visible the cycle after.
// No backpressure; asynchronous active-low clear.
module wrap_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ones_run_gen.sv
// Serial run generator: each accepted start emits len 1s then GAP_CYC 0s; o rises the cycle after acceptance.
// start is only taken while ready (IDLE); ONES_RUN_REPEAT_EN adds rpt to chain runs without returning to IDLE.
module ones_run_gen
  import ones_run_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int THRESH  = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
`ifdef ONES_RUN_REPEAT_EN
  input  logic             rpt,
`endif
  output logic             ready,
  output logic             o,
  output logic             last,
  output logic             done,
  output logic [CNT_W-1:0] runs,
  output logic [CNT_W-1:0] hits
);

  // Counter must hold both the longest run and the longest gap (15).
  localparam int CW = (LEN_W > 4) ? LEN_W : 4;
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] TWO    = CW'(2);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic             r_o;
  logic             r_last;
  logic             r_done;
  logic             r_ready;

  logic w_rpt;
  logic w_hit;
  logic w_gap_exit;

`ifdef ONES_RUN_REPEAT_EN
  assign w_rpt = rpt;
`else
  assign w_rpt = 1'b0;
`endif

  assign w_hit      = (int'(r_len_q) >= THRESH);
  assign w_gap_exit = (r_state == GAP) && (r_cnt == ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len_q <= '0;
      r_o     <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len_q <= len;
            r_ready <= 1'b0;
            if (len != '0) begin
              r_state <= ONES;
              r_cnt   <= CW'(len);
              r_o     <= 1'b1;
              r_last  <= (CW'(len) == ONE);
            end else begin
              r_state <= GAP;
              r_cnt   <= GAP_LD;
              r_done  <= (GAP_LD == ONE);
            end
          end
        end
        ONES: begin
          if (r_cnt == ONE) begin
            r_state <= GAP;
            r_cnt   <= GAP_LD;
            r_o     <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= (GAP_LD == ONE);
          end else begin
            r_cnt  <= r_cnt - ONE;
            r_last <= (r_cnt == TWO);
          end
        end
        GAP: begin
          if (r_cnt == ONE) begin
            r_done <= 1'b0;
            if (w_rpt && (r_len_q != '0)) begin
              r_state <= ONES;
              r_cnt   <= CW'(r_len_q);
              r_o     <= 1'b1;
              r_last  <= (CW'(r_len_q) == ONE);
            end else if (w_rpt) begin
              // Zero-length repeat: stay in GAP and keep pulsing done.
              r_cnt  <= GAP_LD;
              r_done <= (GAP_LD == ONE);
            end else begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
          end else begin
            r_cnt  <= r_cnt - ONE;
            r_done <= (r_cnt == TWO);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  wrap_cnt #(.W(CNT_W)) u_runs_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_gap_exit),
    .o_cnt   (runs)
  );

  wrap_cnt #(.W(CNT_W)) u_hits_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_gap_exit && w_hit),
    .o_cnt   (hits)
  );

  assign o     = r_o;
  assign last  = r_last;
  assign done  = r_done;
  assign ready = r_ready;

endmodule

// File: tb/tb_ones_run_gen.sv
// Bench for ones_run_gen: queue-based line model checked every cycle, plus directed literal checks.
// Repeat-mode checks are built only when ONES_RUN_REPEAT_EN is defined.
module tb_ones_run_gen;

  localparam int LEN_W   = 4;
  localparam int GAP_CYC = 1;
  localparam int THRESH  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             rpt = 1'b0;
  logic             ready, o, last, done;
  logic [7:0]       runs, hits;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ones_run_gen #(.LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .THRESH(THRESH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
`ifdef ONES_RUN_REPEAT_EN
    .rpt   (rpt),
`endif
    .ready (ready),
    .o     (o),
    .last  (last),
    .done  (done),
    .runs  (runs),
    .hits  (hits)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the line is a queue of per-cycle symbols built from each accepted request.
  typedef struct {
    bit vld;
    bit o;
    bit last;
    bit done;
    bit hit;
    int len;
  } sym_t;

  sym_t     q[$];
  sym_t     cur;
  int       m_runs, m_hits;

  function automatic void push_run(input int l);
    sym_t s;
    for (int i = 0; i < l; i++) begin
      s = '{vld: 1'b1, o: 1'b1, last: (i == l - 1), done: 1'b0, hit: (l >= THRESH), len: l};
      q.push_back(s);
    end
    for (int g = 0; g < GAP_CYC; g++) begin
      s = '{vld: 1'b1, o: 1'b0, last: 1'b0, done: (g == GAP_CYC - 1), hit: (l >= THRESH), len: l};
      q.push_back(s);
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cur    = '{default: 0};
      m_runs = 0;
      m_hits = 0;
    end else begin
      if (cur.vld && cur.done) begin
        m_runs = (m_runs + 1) % 256;
        if (cur.hit) m_hits = (m_hits + 1) % 256;
`ifdef ONES_RUN_REPEAT_EN
        if (rpt) push_run(cur.len);
`endif
      end
      if (!cur.vld && start) push_run(int'(len));
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{default: 0};
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("o", o, cur.vld & cur.o);
      chk("last", last, cur.vld & cur.last);
      chk("done", done, cur.vld & cur.done);
      chk("ready", ready, !cur.vld);
      chk("runs", runs, m_runs);
      chk("hits", hits, m_hits);
      chk("o_done_excl", o & done, 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  // Present start for exactly one edge at the current negedge.
  task automatic send(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [3:0] v4;
  logic [9:0] v10;
  int         ones_cnt;
  int         guard;

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_o", o, 0);
    chk("rst_ready", ready, 1);
    chk("rst_last_done", {last, done}, 0);
    chk("rst_runs", runs, 0);
    chk("rst_hits", hits, 0);
    #4 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // len=3: o=1110 after acceptance, last on the third 1, done on the 0.
    send(3);
    for (int i = 3; i >= 0; i--) begin
      v4[i] = o;
      if (i == 1) chk("len3_last", last, 1);
      if (i == 0) chk("len3_done", done, 1);
      @(negedge clk);
    end
    chk("len3_stream", v4, 4'b1110);
    chk("len3_runs", runs, 1);
    chk("len3_hits", hits, 1);
    chk("len3_ready", ready, 1);

    // len=2 then len=5 with start held: the second request waits for IDLE.
    do_reset();
    start = 1'b1;
    len   = 4'd2;
    @(negedge clk);
    len = 4'd5;
    for (int i = 9; i >= 0; i--) begin
      v10[i] = o;
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b_stream", v10, 10'b1100111110);
    repeat (3) @(negedge clk);
    chk("b2b_runs", runs, 2);
    chk("b2b_hits", hits, 1);
    chk("b2b_idle_o", o, 0);

    // len=0: no 1s, done one cycle after acceptance, runs+1 only.
    do_reset();
    send(0);
    chk("len0_o", o, 0);
    chk("len0_done", done, 1);
    @(negedge clk);
    chk("len0_done_gone", done, 0);
    chk("len0_runs", runs, 1);
    chk("len0_hits", hits, 0);

    // len=15: fifteen consecutive 1s.
    send(15);
    ones_cnt = 0;
    guard    = 0;
    while (o && guard < 40) begin
      ones_cnt++;
      guard++;
      @(negedge clk);
    end
    chk("len15_ones", ones_cnt, 15);
    repeat (2) @(negedge clk);
    chk("len15_runs", runs, 2);
    chk("len15_hits", hits, 1);

    // Wrap: 255 runs of len=3 at 5 cycles each, then one more wraps both to 0.
    do_reset();
    start = 1'b1;
    len   = 4'd3;
    repeat (1275) @(negedge clk);
    start = 1'b0;
    chk("wrap255_runs", runs, 255);
    chk("wrap255_hits", hits, 255);
    send(3);
    repeat (5) @(negedge clk);
    chk("wrap256_runs", runs, 0);
    chk("wrap256_hits", hits, 0);

    // Mid-run asynchronous reset drops o without a clock edge.
    send(5);
    @(negedge clk);
    chk("pre_rst_o", o, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_o", o, 0);
    chk("async_rst_ready", ready, 1);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

`ifdef ONES_RUN_REPEAT_EN
    // Repeat: continuous 1110 with ready low; dropping rpt returns to IDLE after the gap.
    do_reset();
    rpt = 1'b1;
    send(3);
    for (int i = 0; i < 12; i++) begin
      chk("rpt_o", o, (i % 4) != 3);
      chk("rpt_ready", ready, 0);
      @(negedge clk);
      if (i == 10) rpt = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rpt_ready_back", ready, 1);
    chk("rpt_runs", runs, 3);
    chk("rpt_hits", hits, 3);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
